// File: rtl/tower_slot_mgr.sv
// Tower slot manager: build/sell/upgrade command FSM with per-slot tower state and a
// registered draw selector. Optional upgrade support is enabled by defining TOWER_UPGRADE_EN.
module tower_slot_mgr #(
    parameter int NUM_SLOTS    = 8,
    parameter int TYPE_W       = 3,
    parameter int OFS_W        = 32,
    parameter int BUILD_CYCLES = 4,
    localparam int LOC_W       = $clog2(NUM_SLOTS)
) (
    input  logic                          Clk,
    input  logic                          Reset,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [1:0]                    cmd_op,
    input  logic [LOC_W-1:0]              cmd_loc,
    input  logic [TYPE_W-1:0]             cmd_type,
    input  logic [NUM_SLOTS-1:0]          print_array,
    input  logic [NUM_SLOTS*OFS_W-1:0]    offsetx_array,
    input  logic [NUM_SLOTS*OFS_W-1:0]    offsety_array,
    output logic [NUM_SLOTS-1:0]          occupied,
    output logic [NUM_SLOTS-1:0]          toi_enable_array,
    output logic [NUM_SLOTS-1:0]          toi_sell_array,
    output logic [NUM_SLOTS*TYPE_W-1:0]   toi_type_array,
    output logic                          cmd_err,
    output logic                          print_valid,
    output logic [TYPE_W-1:0]             print_type,
    output logic signed [OFS_W-1:0]       offset_towerx,
    output logic signed [OFS_W-1:0]       offset_towery
`ifdef TOWER_UPGRADE_EN
    ,
    output logic [NUM_SLOTS*2-1:0]        toi_level_array
`endif
);

    localparam int CNT_W = (BUILD_CYCLES > 1) ? $clog2(BUILD_CYCLES) : 1;
    localparam logic [LOC_W:0] SLOT_LIM = (LOC_W+1)'(NUM_SLOTS);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BUILD = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t              state, state_nxt;
    logic [CNT_W-1:0]    cnt;
    logic [LOC_W-1:0]    bld_loc;
    logic [TYPE_W-1:0]   bld_type;

    logic                accept;
    logic                loc_ok;
    logic                occ_at;
    logic                do_build, do_sell, do_upg, do_err;
`ifdef TOWER_UPGRADE_EN
    logic [1:0]          level_at;
`endif

    logic                hit_p0;
    logic [LOC_W-1:0]    sel_p0;

    // Command decode and FSM next-state
    always_comb begin
        state_nxt = state;
        cmd_ready = (state == S_IDLE);
        accept    = cmd_valid && cmd_ready;
        loc_ok    = ({1'b0, cmd_loc} < SLOT_LIM);
        occ_at    = loc_ok ? occupied[cmd_loc] : 1'b0;
        do_build  = 1'b0;
        do_sell   = 1'b0;
        do_upg    = 1'b0;
        do_err    = 1'b0;
`ifdef TOWER_UPGRADE_EN
        level_at  = loc_ok ? toi_level_array[int'(cmd_loc)*2 +: 2] : 2'd0;
`endif
        if (accept) begin
            case (cmd_op)
                2'b01: begin
                    if (loc_ok && !occ_at && (cmd_type != '0)) do_build = 1'b1;
                    else                                        do_err   = 1'b1;
                end
                2'b10: begin
                    if (loc_ok && occ_at) do_sell = 1'b1;
                    else                  do_err  = 1'b1;
                end
                2'b11: begin
`ifdef TOWER_UPGRADE_EN
                    if (loc_ok && occ_at && (level_at != 2'd3)) do_upg = 1'b1;
                    else                                         do_err = 1'b1;
`else
                    do_err = 1'b1;
`endif
                end
                default: ;
            endcase
        end

        case (state)
            S_IDLE:  if (do_build) state_nxt = S_BUILD;
            S_BUILD: if (cnt == '0) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Slot state and command side effects
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state            <= S_IDLE;
            cnt              <= '0;
            bld_loc          <= '0;
            bld_type         <= '0;
            occupied         <= '0;
            toi_enable_array <= '0;
            toi_sell_array   <= '0;
            toi_type_array   <= '0;
            cmd_err          <= 1'b0;
`ifdef TOWER_UPGRADE_EN
            toi_level_array  <= '0;
`endif
        end else begin
            state            <= state_nxt;
            cmd_err          <= do_err;
            toi_enable_array <= '0;
            toi_sell_array   <= '0;

            case (state)
                S_IDLE: begin
                    if (do_build) begin
                        bld_loc  <= cmd_loc;
                        bld_type <= cmd_type;
                        cnt      <= CNT_W'(BUILD_CYCLES - 1);
                    end
                    if (do_sell) begin
                        occupied[cmd_loc]                          <= 1'b0;
                        toi_type_array[int'(cmd_loc)*TYPE_W +: TYPE_W] <= '0;
                        toi_sell_array[cmd_loc]                    <= 1'b1;
`ifdef TOWER_UPGRADE_EN
                        toi_level_array[int'(cmd_loc)*2 +: 2]      <= 2'd0;
`endif
                    end
`ifdef TOWER_UPGRADE_EN
                    if (do_upg) toi_level_array[int'(cmd_loc)*2 +: 2] <= level_at + 2'd1;
`endif
                end
                S_BUILD: if (cnt != '0) cnt <= cnt - 1'b1;
                S_DONE: begin
                    occupied[bld_loc]                              <= 1'b1;
                    toi_type_array[int'(bld_loc)*TYPE_W +: TYPE_W] <= bld_type;
                    toi_enable_array[bld_loc]                      <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Draw select p0: lowest-index requested slot that holds a tower
    always_comb begin
        hit_p0 = 1'b0;
        sel_p0 = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (print_array[i] && occupied[i]) begin
                hit_p0 = 1'b1;
                sel_p0 = LOC_W'(i);
            end
        end
    end

    // Draw select p1: registered outputs
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            print_valid   <= 1'b0;
            print_type    <= '0;
            offset_towerx <= '0;
            offset_towery <= '0;
        end else begin
            print_valid   <= hit_p0;
            print_type    <= hit_p0 ? toi_type_array[int'(sel_p0)*TYPE_W +: TYPE_W] : '0;
            offset_towerx <= hit_p0 ? offsetx_array[int'(sel_p0)*OFS_W +: OFS_W] : '0;
            offset_towery <= hit_p0 ? offsety_array[int'(sel_p0)*OFS_W +: OFS_W] : '0;
        end
    end

    // do_upg is only consumed when upgrades are built in
    logic unused_ok;
    assign unused_ok = do_upg;

endmodule

// File: tb/tb_tower_slot_mgr.sv
// Scoreboard bench for tower_slot_mgr: directed commands push expected pulse events,
// a negedge monitor pops and compares every enable/sell/err pulse the DUT shows.
module tb_tower_slot_mgr;

    localparam int NS = 8;
    localparam int TW = 3;
    localparam int OW = 32;
    localparam int BC = 4;

    logic                  Clk = 1'b0;
    logic                  Reset;
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [1:0]            cmd_op;
    logic [2:0]            cmd_loc;
    logic [TW-1:0]         cmd_type;
    logic [NS-1:0]         print_array;
    logic [NS*OW-1:0]      offsetx_array;
    logic [NS*OW-1:0]      offsety_array;
    logic [NS-1:0]         occupied;
    logic [NS-1:0]         toi_enable_array;
    logic [NS-1:0]         toi_sell_array;
    logic [NS*TW-1:0]      toi_type_array;
    logic                  cmd_err;
    logic                  print_valid;
    logic [TW-1:0]         print_type;
    logic signed [OW-1:0]  offset_towerx;
    logic signed [OW-1:0]  offset_towery;
`ifdef TOWER_UPGRADE_EN
    logic [NS*2-1:0]       toi_level_array;
`endif

    tower_slot_mgr #(
        .NUM_SLOTS(NS), .TYPE_W(TW), .OFS_W(OW), .BUILD_CYCLES(BC)
    ) dut (
        .Clk(Clk),
        .Reset(Reset),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_op(cmd_op),
        .cmd_loc(cmd_loc),
        .cmd_type(cmd_type),
        .print_array(print_array),
        .offsetx_array(offsetx_array),
        .offsety_array(offsety_array),
        .occupied(occupied),
        .toi_enable_array(toi_enable_array),
        .toi_sell_array(toi_sell_array),
        .toi_type_array(toi_type_array),
        .cmd_err(cmd_err),
        .print_valid(print_valid),
        .print_type(print_type),
        .offset_towerx(offset_towerx),
        .offset_towery(offset_towery)
`ifdef TOWER_UPGRADE_EN
        ,
        .toi_level_array(toi_level_array)
`endif
    );

    always #5 Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    // kind: 0 build-complete pulse, 1 sell pulse, 2 error pulse
    typedef struct {
        int           kind;
        logic [NS-1:0] vec;
        int           at;
    } ev_t;

    ev_t exp_q[$];
    ev_t obs_ev;
    ev_t exp_ev;
    int  n_tests = 0;
    int  n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic expect_ev(input int kind, input logic [NS-1:0] vec, input int at);
        ev_t e;
        e.kind = kind;
        e.vec  = vec;
        e.at   = at;
        exp_q.push_back(e);
    endtask

    function automatic logic signed [OW-1:0] offx(input int i);
        return OW'(100 + i * 7);
    endfunction

    function automatic logic signed [OW-1:0] offy(input int i);
        return OW'(-(i + 1) * 16);
    endfunction

    // Monitor: any pulse on enable/sell/err must match the head of the expected queue
    always @(negedge Clk) begin
        if (Reset === 1'b0) begin
            if ((|toi_enable_array) || (|toi_sell_array) || cmd_err) begin
                obs_ev.kind = cmd_err ? 2 : ((|toi_sell_array) ? 1 : 0);
                obs_ev.vec  = cmd_err ? '0 : ((|toi_sell_array) ? toi_sell_array : toi_enable_array);
                obs_ev.at   = cyc;
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_event: got kind=%0d vec=%b at cycle %0d, expected none",
                             obs_ev.kind, obs_ev.vec, obs_ev.at);
                end else begin
                    exp_ev = exp_q.pop_front();
                    check("event_kind",  64'(obs_ev.kind), 64'(exp_ev.kind));
                    check("event_vec",   64'(obs_ev.vec),  64'(exp_ev.vec));
                    check("event_cycle", 64'(obs_ev.at),   64'(exp_ev.at));
                end
            end
        end
    end

    task automatic wait_ready();
        int k;
        k = 0;
        @(negedge Clk);
        while (!cmd_ready && k < 50) begin
            @(negedge Clk);
            k++;
        end
        if (!cmd_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL ready_timeout: got cmd_ready=0, expected 1 within 50 cycles");
        end
    endtask

    // Issue one command; acc returns the cycle index right after the accepting edge
    task automatic send(input logic [1:0] op, input int loc, input int typ, output int acc);
        wait_ready();
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_loc   = loc[2:0];
        cmd_type  = typ[TW-1:0];
        @(posedge Clk);
        #1;
        acc       = cyc;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
    endtask

    int a;

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before 200000 time units");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset       = 1'b1;
        cmd_valid   = 1'b0;
        cmd_op      = 2'b00;
        cmd_loc     = '0;
        cmd_type    = '0;
        print_array = '0;
        for (int i = 0; i < NS; i++) begin
            offsetx_array[i*OW +: OW] = offx(i);
            offsety_array[i*OW +: OW] = offy(i);
        end
        repeat (3) @(posedge Clk);
        #1;
        check("rst_occupied",   64'(occupied), 64'(0));
        check("rst_ready",      64'(cmd_ready), 64'(1));
        check("rst_types",      64'(toi_type_array), 64'(0));
        check("rst_err",        64'(cmd_err), 64'(0));
        check("rst_print_valid", 64'(print_valid), 64'(0));
        @(negedge Clk);
        Reset = 1'b0;

        // Build slot 2 type 5: pulse BUILD_CYCLES+1 cycles after accept
        send(2'b01, 2, 5, a);
        expect_ev(0, 8'b0000_0100, a + BC + 1);
        wait_ready();
        check("build_occupied", 64'(occupied), 64'h04);
        check("build_type2",    64'(toi_type_array[2*TW +: TW]), 64'd5);

        // Rebuild an occupied slot
        send(2'b01, 2, 3, a);
        expect_ev(2, '0, a);
        @(negedge Clk);
        check("rebuild_occupied", 64'(occupied), 64'h04);
        check("rebuild_types",    64'(toi_type_array), 64'h140);

        // Sell slot 2, then sell it again
        send(2'b10, 2, 0, a);
        expect_ev(1, 8'b0000_0100, a);
        @(negedge Clk);
        check("sell_occupied", 64'(occupied), 64'h00);
        check("sell_types",    64'(toi_type_array), 64'h0);
        send(2'b10, 2, 0, a);
        expect_ev(2, '0, a);

        // Build with type 0, nop, upgrade of an empty slot
        send(2'b01, 3, 0, a);
        expect_ev(2, '0, a);
        send(2'b00, 5, 1, a);
        @(negedge Clk);
        check("nop_occupied", 64'(occupied), 64'h00);
        send(2'b11, 4, 0, a);
        expect_ev(2, '0, a);

        // Build slots 1 and 6; a command offered during BUILD is dropped
        send(2'b01, 1, 3, a);
        expect_ev(0, 8'b0000_0010, a + BC + 1);
        send(2'b01, 6, 7, a);
        expect_ev(0, 8'b0100_0000, a + BC + 1);
        @(negedge Clk);
        cmd_valid = 1'b1;
        cmd_op    = 2'b01;
        cmd_loc   = 3'd0;
        cmd_type  = 3'd2;
        repeat (2) @(negedge Clk);
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        wait_ready();
        repeat (2) @(negedge Clk);
        check("two_built_occupied", 64'(occupied), 64'h42);
        check("two_built_types", 64'(toi_type_array), 64'((24'd7 << 18) | (24'd3 << 3)));

        // Draw select
        print_array = 8'h42;
        @(negedge Clk);
        check("draw42_valid", 64'(print_valid), 64'd1);
        check("draw42_type",  64'(print_type), 64'd3);
        check("draw42_x",     64'(offset_towerx), 64'(offx(1)));
        check("draw42_y",     64'(offset_towery), 64'(offy(1)));
        print_array = 8'h80;
        @(negedge Clk);
        check("draw80_valid", 64'(print_valid), 64'd0);
        check("draw80_type",  64'(print_type), 64'd0);
        check("draw80_x",     64'(offset_towerx), 64'd0);
        print_array = 8'hC0;
        @(negedge Clk);
        check("drawC0_valid", 64'(print_valid), 64'd1);
        check("drawC0_type",  64'(print_type), 64'd7);
        check("drawC0_y",     64'(offset_towery), 64'(offy(6)));
        print_array = 8'h01;
        @(negedge Clk);
        check("draw01_valid", 64'(print_valid), 64'd0);

        // Upgrades on slot 1
`ifdef TOWER_UPGRADE_EN
        for (int u = 1; u <= 3; u++) begin
            send(2'b11, 1, 0, a);
            @(negedge Clk);
            check("upgrade_level", 64'(toi_level_array[2*2-1:2]), 64'(u));
        end
        send(2'b11, 1, 0, a);
        expect_ev(2, '0, a);
        @(negedge Clk);
        check("upgrade_sat_level", 64'(toi_level_array[3:2]), 64'd3);
        send(2'b10, 1, 0, a);
        expect_ev(1, 8'b0000_0010, a);
        @(negedge Clk);
        check("sell_clears_level", 64'(toi_level_array[3:2]), 64'd0);
`else
        send(2'b11, 1, 0, a);
        expect_ev(2, '0, a);
        @(negedge Clk);
        check("upgrade_nochange_occ", 64'(occupied), 64'h42);
`endif

        // Reset two cycles into BUILD aborts the construction
        send(2'b01, 4, 2, a);
        repeat (2) @(negedge Clk);
        Reset = 1'b1;
        #1;
        check("abort_occupied_now", 64'(occupied), 64'h00);
        check("abort_ready_now",    64'(cmd_ready), 64'd1);
        check("abort_types_now",    64'(toi_type_array), 64'h0);
        @(negedge Clk);
        Reset = 1'b0;
        repeat (10) @(negedge Clk);
        check("abort_occupied_later", 64'(occupied), 64'h00);
        check("abort_ready_later",    64'(cmd_ready), 64'd1);

        check("events_outstanding", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
